// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - per-lane partial-sum accumulator with saturating row output
module psum_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int TILE_SIZE  = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_start,
  input  logic [6:0]                      cfg_num_ktiles,
  input  logic [7:0]                      cfg_num_rows,
  input  logic                            cfg_mode,
  input  logic                            tile_valid,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0] tile_data,
  output logic                            hold,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TILE_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                            out_mode,
  output logic                            out_last,
  output logic                            busy,
  output logic                            job_done,
  output logic [1:0]                      err_flags
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Saturation bounds expressed at accumulator width so the compare is a plain signed compare.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                           state_q, state_d;
  logic [6:0]                       num_ktiles_q;
  logic [7:0]                       num_rows_q;
  logic                             mode_q;
  logic [6:0]                       ktile_cnt;
  logic [7:0]                       row_cnt;
  logic signed [ACC_WIDTH-1:0]      acc [TILE_SIZE];
  logic signed [ACC_WIDTH-1:0]      sum [TILE_SIZE];
  logic [TILE_SIZE*DATA_WIDTH-1:0]  sat_vec;
  logic [TILE_SIZE*DATA_WIDTH-1:0]  out_data_q;
  logic                             clip;
  logic [1:0]                       err_q;
  logic                             job_done_q;

  logic start_acc;
  logic beat;
  logic final_beat;
  logic drop;
  logic handshake;
  logic row_is_last;

  assign row_is_last = (row_cnt == num_rows_q - 8'd1);
  assign out_data    = out_data_q;
  assign out_mode    = mode_q;
  assign out_last    = out_valid && row_is_last;
  assign err_flags   = err_q;
  assign job_done    = job_done_q;

  // Per-lane running sum including the current beat, and its saturated DATA_WIDTH image.
  always_comb begin
    clip    = 1'b0;
    sat_vec = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      sum[i] = acc[i] + {{(ACC_WIDTH-DATA_WIDTH){tile_data[i*DATA_WIDTH+DATA_WIDTH-1]}},
                         tile_data[i*DATA_WIDTH +: DATA_WIDTH]};
      if (sum[i] > SAT_MAX) begin
        sat_vec[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
        clip = 1'b1;
      end else if (sum[i] < SAT_MIN) begin
        sat_vec[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
        clip = 1'b1;
      end else begin
        sat_vec[i*DATA_WIDTH +: DATA_WIDTH] = sum[i][DATA_WIDTH-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus the per-cycle event strobes the datapath consumes.
  always_comb begin
    state_d    = state_q;
    start_acc  = 1'b0;
    beat       = 1'b0;
    final_beat = 1'b0;
    drop       = 1'b0;
    handshake  = 1'b0;
    hold       = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (cfg_start) begin
          start_acc = 1'b1;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (tile_valid) begin
          beat = 1'b1;
          if (ktile_cnt == num_ktiles_q - 7'd1) begin
            final_beat = 1'b1;
            state_d    = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        hold      = 1'b1;
        out_valid = 1'b1;
        drop      = tile_valid;
        if (out_ready) begin
          handshake = 1'b1;
          state_d   = row_is_last ? IDLE : ACCUM;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Job configuration, zero counts promoted to one so every job produces at least one beat/row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_ktiles_q <= 7'd0;
      num_rows_q   <= 8'd0;
      mode_q       <= 1'b0;
    end else if (start_acc) begin
      num_ktiles_q <= (cfg_num_ktiles == 7'd0) ? 7'd1 : cfg_num_ktiles;
      num_rows_q   <= (cfg_num_rows == 8'd0) ? 8'd1 : cfg_num_rows;
      mode_q       <= cfg_mode;
    end
  end

  // K-tile and row counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ktile_cnt <= 7'd0;
      row_cnt   <= 8'd0;
    end else if (start_acc) begin
      ktile_cnt <= 7'd0;
      row_cnt   <= 8'd0;
    end else if (beat) begin
      ktile_cnt <= ktile_cnt + 7'd1;
    end else if (handshake && !row_is_last) begin
      ktile_cnt <= 7'd0;
      row_cnt   <= row_cnt + 8'd1;
    end
  end

  // Lane accumulators: cleared at job start and after each accepted non-final row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
    end else if (start_acc || (handshake && !row_is_last)) begin
      for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
    end else if (beat) begin
      for (int i = 0; i < TILE_SIZE; i++) acc[i] <= sum[i];
    end
  end

  // Result register captured on the final K-tile beat and held through the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          out_data_q <= '0;
    else if (final_beat) out_data_q <= sat_vec;
  end

  // Sticky error flags and the end-of-job pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 2'b00;
      job_done_q <= 1'b0;
    end else begin
      job_done_q <= handshake && row_is_last;
      if (start_acc) begin
        err_q <= 2'b00;
      end else begin
        if (final_beat && clip) err_q[0] <= 1'b1;
        if (drop)               err_q[1] <= 1'b1;
      end
    end
  end

endmodule
